aes_block_sequencer: RTL and testbench

AES_BLOCK_SEQUENCER -- requirements
Module: aes_block_sequencer

---
 rtl/aes_demo_pkg.sv | 32 +++
 rtl/aes_result_buf.sv | 45 ++++
 rtl/aes_block_sequencer.sv | 146 ++++++++++++++
 tb/tb_aes_block_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_demo_pkg.sv
// rtl/aes_demo_pkg.sv - shared widths, FSM state type and plaintext generator for the AES block sequencer
//
// Contents:
//   WORD_W / BLOCK_W  : display word and AES block widths
//   seq_state_t       : sequencer FSM state encoding
//   make_plaintext()  : generated plaintext block, byte j (j=0 MSB) = seed + 16*blk + j mod 256

package aes_demo_pkg;

    localparam int WORD_W  = 32;
    localparam int BLOCK_W = 128;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD       = 3'd1,
        ST_WAIT_VALID = 3'd2,
        ST_WAIT_DROP  = 3'd3,
        ST_DONE       = 3'd4,
        ST_ERROR      = 3'd5
    } seq_state_t;

    // Byte arithmetic is deliberately 8 bits wide so the mod-256 wrap is free.
    function automatic logic [BLOCK_W-1:0] make_plaintext(input logic [7:0] seed,
                                                          input logic [3:0] blk);
        logic [BLOCK_W-1:0] pt;
        for (int j = 0; j < 16; j++) begin
            pt[BLOCK_W-1-8*j -: 8] = seed + {blk, 4'h0} + 8'(j);
        end
        return pt;
    endfunction

endpackage

// File: rtl/aes_result_buf.sv
// rtl/aes_result_buf.sv - ciphertext result storage with one block write port and a word read port
//
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset (clears every entry)
//   wr_en/wr_idx/wr_data : write one 128-bit block
//   rd_idx/rd_word     : block and word select for the display read
//   rd_data            : combinational 32-bit word; word 3 is the most significant

module aes_result_buf
    import aes_demo_pkg::*;
#(
    parameter int NUM_BLOCKS = 4,
    parameter int BW         = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [BW-1:0]      wr_idx,
    input  logic [BLOCK_W-1:0] wr_data,
    input  logic [BW-1:0]      rd_idx,
    input  logic [1:0]         rd_word,
    output logic [WORD_W-1:0]  rd_data
);

    logic [BLOCK_W-1:0] mem [NUM_BLOCKS];
    logic [BLOCK_W-1:0] rd_blk;

    // Only the addressed entry is written, so a new run leaves later
    // entries holding the previous run's results until it reaches them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_blk  = mem[rd_idx];
        rd_data = rd_blk[{rd_word, 5'd0} +: WORD_W];
    end

endmodule

// File: rtl/aes_block_sequencer.sv
// rtl/aes_block_sequencer.sv - feeds generated plaintext blocks to an AES core (ECB or CBC) and displays results
//
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   btn_start                      : start a run (only honoured in IDLE, DONE or ERROR)
//   btn_block / btn_word           : step displayed block (up, wrapping) / word (down, wrapping)
//   core_load, core_pt             : level request and plaintext to the core
//   core_ct, core_valid            : core result; valid is held until core_load falls
//   disp_data, blk_idx, word_idx   : displayed ciphertext word and its indices
//   busy, done, err                : run in progress / run complete / core timed out

module aes_block_sequencer
    import aes_demo_pkg::*;
#(
    parameter int                 NUM_BLOCKS = 4,
    parameter int                 CBC_MODE   = 0,
    parameter logic [BLOCK_W-1:0] IV         = 128'h0,
    parameter logic [7:0]         PT_SEED    = 8'h05,
    parameter int                 TIMEOUT    = 1024,
    localparam int                BW         = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_start,
    input  logic               btn_block,
    input  logic               btn_word,
    output logic               core_load,
    output logic [BLOCK_W-1:0] core_pt,
    input  logic [BLOCK_W-1:0] core_ct,
    input  logic               core_valid,
    output logic [WORD_W-1:0]  disp_data,
    output logic [BW-1:0]      blk_idx,
    output logic [1:0]         word_idx,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [BW-1:0] LAST_BLK = BW'(NUM_BLOCKS - 1);

    seq_state_t         state;
    logic [BW-1:0]      blk_n;
    logic [TW-1:0]      tmo_cnt;
    logic [BLOCK_W-1:0] chain_q;
    logic [BLOCK_W-1:0] plain;
    logic               start_ok;
    logic               res_wr;

    assign plain    = make_plaintext(PT_SEED, 4'(blk_n));
    assign start_ok = btn_start &&
                      ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
    assign res_wr   = (state == ST_WAIT_VALID) && core_valid;

    // chain_q carries the CBC "previous" value: IV at run start, then the
    // most recently captured ciphertext. Keeping a copy here avoids a second
    // full-block read port on the result buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            blk_n     <= '0;
            tmo_cnt   <= '0;
            core_load <= 1'b0;
            core_pt   <= '0;
            chain_q   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start_ok) begin
                        blk_n   <= '0;
                        chain_q <= IV;
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    core_pt   <= (CBC_MODE != 0) ? (plain ^ chain_q) : plain;
                    core_load <= 1'b1;
                    tmo_cnt   <= '0;
                    state     <= ST_WAIT_VALID;
                end
                ST_WAIT_VALID: begin
                    // A result arriving on the last allowed cycle still wins
                    // over the timeout.
                    if (core_valid) begin
                        core_load <= 1'b0;
                        chain_q   <= core_ct;
                        state     <= ST_WAIT_DROP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        core_load <= 1'b0;
                        tmo_cnt   <= '0;
                        state     <= ST_ERROR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_WAIT_DROP: begin
                    if (!core_valid) begin
                        if (blk_n == LAST_BLK) begin
                            state <= ST_DONE;
                        end else begin
                            blk_n <= blk_n + 1'b1;
                            state <= ST_LOAD;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Display indices are independent of the FSM so buttons work in any state
    // and in the same cycle as a start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_idx  <= '0;
            word_idx <= 2'd3;
        end else begin
            if (btn_block) begin
                blk_idx <= (blk_idx == LAST_BLK) ? '0 : blk_idx + 1'b1;
            end
            if (btn_word) begin
                word_idx <= word_idx - 2'd1;
            end
        end
    end

    assign busy = (state == ST_LOAD) || (state == ST_WAIT_VALID) || (state == ST_WAIT_DROP);
    assign done = (state == ST_DONE);
    assign err  = (state == ST_ERROR);

    aes_result_buf #(
        .NUM_BLOCKS (NUM_BLOCKS),
        .BW         (BW)
    ) u_result_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (res_wr),
        .wr_idx  (blk_n),
        .wr_data (core_ct),
        .rd_idx  (blk_idx),
        .rd_word (word_idx),
        .rd_data (disp_data)
    );

endmodule

// File: tb/tb_aes_block_sequencer.sv
// tb/tb_aes_block_sequencer.sv - scoreboard bench for aes_block_sequencer (ECB and CBC instances)

module tb_aes_block_sequencer;

    localparam int           NB   = 4;
    localparam int           TMO  = 16;
    localparam logic [7:0]   SEED = 8'h05;
    localparam logic [127:0] IV1  = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic btn_start, btn_block, btn_word;
    logic mute;

    logic [1:0]        core_load;
    logic [1:0][127:0] core_pt;
    logic [1:0][127:0] core_ct;
    logic [1:0]        core_valid;
    logic [1:0][31:0]  disp_data;
    logic [1:0][1:0]   blk_idx;
    logic [1:0][1:0]   word_idx;
    logic [1:0]        busy, done, err;

    aes_block_sequencer #(
        .NUM_BLOCKS(NB), .CBC_MODE(0), .IV(128'h0), .PT_SEED(SEED), .TIMEOUT(TMO)
    ) dut_ecb (
        .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_block(btn_block),
        .btn_word(btn_word), .core_load(core_load[0]), .core_pt(core_pt[0]),
        .core_ct(core_ct[0]), .core_valid(core_valid[0]), .disp_data(disp_data[0]),
        .blk_idx(blk_idx[0]), .word_idx(word_idx[0]), .busy(busy[0]), .done(done[0]),
        .err(err[0])
    );

    aes_block_sequencer #(
        .NUM_BLOCKS(NB), .CBC_MODE(1), .IV(IV1), .PT_SEED(SEED), .TIMEOUT(TMO)
    ) dut_cbc (
        .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_block(btn_block),
        .btn_word(btn_word), .core_load(core_load[1]), .core_pt(core_pt[1]),
        .core_ct(core_ct[1]), .core_valid(core_valid[1]), .disp_data(disp_data[1]),
        .blk_idx(blk_idx[1]), .word_idx(word_idx[1]), .busy(busy[1]), .done(done[1]),
        .err(err[1])
    );

    // Mock AES cores: ct = ~pt after a random latency, valid held until load drops.
    int lat_cnt [2];
    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                core_valid[d] <= 1'b0;
                core_ct[d]    <= '0;
                lat_cnt[d]    <= 0;
            end else if (!core_load[d]) begin
                core_valid[d] <= 1'b0;
                lat_cnt[d]    <= int'($urandom_range(2, 12));
            end else if (!core_valid[d] && !mute) begin
                if (lat_cnt[d] <= 1) begin
                    core_valid[d] <= 1'b1;
                    core_ct[d]    <= ~core_pt[d];
                end else begin
                    lat_cnt[d] <= lat_cnt[d] - 1;
                end
            end
        end
    end

    int total, bad;

    // Reference model state
    logic [127:0] model_res [2][NB];
    logic [127:0] exp_mem   [2][32];
    int           wp [2];
    int           rp [2];
    int           m_blk, m_word;

    // Monitor state
    logic [1:0]   ld_q;
    logic [127:0] held [2];
    int           hi_len [2];
    int           last_len [2];
    int           loads_seen [2];

    task automatic check(input string name, input int d, input logic [127:0] act,
                         input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %h want %h", name, d, act, exp);
        end
    endtask

    function automatic logic [127:0] plain(input int n);
        logic [127:0] p;
        for (int j = 0; j < 16; j++) begin
            p[127-8*j -: 8] = 8'((int'(SEED) + 16 * n + j) % 256);
        end
        return p;
    endfunction

    // Push the expected core_pt of each block that will be loaded; record the
    // ciphertexts the run will leave behind when the core answers.
    task automatic issue_run(input int loads);
        logic [127:0] prev;
        logic [127:0] blk_in;
        for (int d = 0; d < 2; d++) begin
            prev = (d == 1) ? IV1 : 128'h0;
            loads_seen[d] = 0;
            for (int n = 0; n < loads; n++) begin
                blk_in = (d == 1) ? (plain(n) ^ prev) : plain(n);
                exp_mem[d][wp[d] % 32] = blk_in;
                wp[d]++;
                if (!mute) begin
                    model_res[d][n] = ~blk_in;
                    prev = ~blk_in;
                end
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (core_load[d] && !ld_q[d]) begin
                    loads_seen[d]++;
                    hi_len[d] = 1;
                    held[d]   = core_pt[d];
                    if (rp[d] == wp[d]) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_load dut%0d: got core_pt %h want no load", d, core_pt[d]);
                    end else begin
                        check("core_pt", d, core_pt[d], exp_mem[d][rp[d] % 32]);
                        rp[d]++;
                    end
                end else if (core_load[d]) begin
                    hi_len[d]++;
                    check("core_pt_stable", d, core_pt[d], held[d]);
                end else if (ld_q[d]) begin
                    last_len[d] = hi_len[d];
                end
                ld_q[d] = core_load[d];
            end
        end
    endtask

    task automatic press(input logic s, input logic b, input logic w);
        btn_start = s;
        btn_block = b;
        btn_word  = w;
        @(negedge clk);
        btn_start = 1'b0;
        btn_block = 1'b0;
        btn_word  = 1'b0;
        if (b) m_blk = (m_blk + 1) % NB;
        if (w) m_word = (m_word + 3) % 4;
    endtask

    task automatic wait_settle(input string name);
        int cyc;
        cyc = 0;
        while (!((done[0] || err[0]) && (done[1] || err[1])) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc >= 3000) begin
            bad++;
            $display("FAIL %s: got no run end within 3000 cycles want done or err", name);
        end
        @(negedge clk);
    endtask

    task automatic check_disp(input string tag);
        for (int d = 0; d < 2; d++) begin
            check({tag, "_blk_idx"}, d, 128'(blk_idx[d]), 128'(m_blk));
            check({tag, "_word_idx"}, d, 128'(word_idx[d]), 128'(m_word));
            check({tag, "_disp"}, d, 128'(disp_data[d]),
                  128'(model_res[d][m_blk][m_word*32 +: 32]));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        for (int d = 0; d < 2; d++) begin
            check({tag, "_core_load"}, d, 128'(core_load[d]), '0);
            check({tag, "_core_pt"}, d, core_pt[d], '0);
            check({tag, "_busy"}, d, 128'(busy[d]), '0);
            check({tag, "_done"}, d, 128'(done[d]), '0);
            check({tag, "_err"}, d, 128'(err[d]), '0);
            check({tag, "_blk_idx"}, d, 128'(blk_idx[d]), '0);
            check({tag, "_word_idx"}, d, 128'(word_idx[d]), 128'(3));
            check({tag, "_disp"}, d, 128'(disp_data[d]), '0);
        end
    endtask

    task automatic check_run_done(input string tag);
        for (int d = 0; d < 2; d++) begin
            check({tag, "_done"}, d, 128'(done[d]), 128'(1));
            check({tag, "_busy"}, d, 128'(busy[d]), '0);
            check({tag, "_err"}, d, 128'(err[d]), '0);
            check({tag, "_loads"}, d, 128'(loads_seen[d]), 128'(NB));
        end
    endtask

    initial begin
        int  cyc;
        logic b, w;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        btn_start = 1'b0;
        btn_block = 1'b0;
        btn_word  = 1'b0;
        mute  = 1'b0;
        ld_q  = '0;
        m_blk = 0;
        m_word = 3;
        for (int d = 0; d < 2; d++) begin
            wp[d] = 0; rp[d] = 0; hi_len[d] = 0; last_len[d] = 0; loads_seen[d] = 0;
            held[d] = '0;
            for (int n = 0; n < NB; n++) model_res[d][n] = '0;
        end
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Run 1 with a start pulse during busy that must be ignored
        issue_run(NB);
        press(1'b1, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        for (int d = 0; d < 2; d++) check("busy_mid_run", d, 128'(busy[d]), 128'(1));
        press(1'b1, 1'b0, 1'b0);
        for (int d = 0; d < 2; d++) check("busy_after_ignored_start", d, 128'(busy[d]), 128'(1));
        wait_settle("run1");
        check_run_done("run1");
        check("ecb_block0_word3", 0, 128'(disp_data[0]), 128'(32'hFAF9F8F7));

        // Walk every word of every block
        for (int bk = 0; bk < NB; bk++) begin
            for (int wd = 0; wd < 4; wd++) begin
                check_disp("walk");
                press(1'b0, 1'b0, 1'b1);
            end
            press(1'b0, 1'b1, 1'b0);
        end
        check_disp("walk_wrap");

        // Core never answers: timeout, then a new start clears the error
        mute = 1'b1;
        issue_run(1);
        press(1'b1, 1'b0, 1'b0);
        wait_settle("timeout");
        for (int d = 0; d < 2; d++) begin
            check("tmo_err", d, 128'(err[d]), 128'(1));
            check("tmo_done", d, 128'(done[d]), '0);
            check("tmo_busy", d, 128'(busy[d]), '0);
            check("tmo_core_load", d, 128'(core_load[d]), '0);
            check("tmo_load_cycles", d, 128'(last_len[d]), 128'(TMO));
        end
        check_disp("after_timeout");
        mute = 1'b0;
        issue_run(NB);
        press(1'b1, 1'b0, 1'b0);
        for (int d = 0; d < 2; d++) begin
            check("restart_err_clear", d, 128'(err[d]), '0);
            check("restart_busy", d, 128'(busy[d]), 128'(1));
        end
        wait_settle("after_err");
        check_run_done("after_err");
        check_disp("after_err");

        // Starts from DONE combined with display buttons, then random browsing
        for (int r = 0; r < 3; r++) begin
            b = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            if (r == 0) begin
                b = 1'b1;
                w = 1'b1;
            end
            issue_run(NB);
            press(1'b1, b, w);
            for (int d = 0; d < 2; d++) begin
                check("combo_busy", d, 128'(busy[d]), 128'(1));
                check("combo_blk_idx", d, 128'(blk_idx[d]), 128'(m_blk));
                check("combo_word_idx", d, 128'(word_idx[d]), 128'(m_word));
            end
            wait_settle("combo_run");
            check_run_done("combo_run");
            repeat (6) begin
                press(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                check_disp("browse");
            end
        end

        // Asynchronous reset during WAIT_VALID of block 2
        issue_run(NB);
        press(1'b1, 1'b0, 1'b0);
        cyc = 0;
        while (loads_seen[0] < 3 && cyc < 500) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("reach_block2", 0, 128'(loads_seen[0]), 128'(3));
        check("block2_load_high", 0, 128'(core_load[0]), 128'(1));
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) check("async_drop_load", d, 128'(core_load[d]), '0);
        for (int d = 0; d < 2; d++) begin
            rp[d] = wp[d];
            for (int n = 0; n < NB; n++) model_res[d][n] = '0;
        end
        m_blk = 0;
        m_word = 3;
        @(negedge clk);
        check_reset_vals("mid_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("after_release");

        issue_run(NB);
        press(1'b1, 1'b0, 1'b0);
        wait_settle("post_reset_run");
        check_run_done("post_reset_run");
        for (int k = 0; k < 4; k++) begin
            check_disp("post_reset");
            press(1'b0, 1'b1, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
